move_exec_arbiter: RTL and testbench

- Shares one move_executor instance among NUM_REQ requesters, for example search workers and the UI/game-state unit.
- Each cycle, selects at most one pending request round-robin and drives it onto the executor input.
- Tags each issued request with its requester index and pairs the executor result with that tag.
- Returns tagged results through a small response FIFO with a valid/ready handshake, using credit-based issue so no result is ever dropped.

---
 rtl/move_exec_arbiter.sv | 178 +++++++++++++++++
 tb/tb_move_exec_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_exec_arbiter.sv
// Round-robin arbiter sharing one move executor among NUM_REQ requesters.
// Issued requests carry an id tag; results return through a credit-guarded FWFT response FIFO.
module move_exec_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ),
    parameter int EXEC_LATENCY = 1,
    parameter int RSP_DEPTH    = 2,
    parameter int MOVE_W       = 12,
    parameter int BOARD_W      = 64
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    input  logic [NUM_REQ-1:0][MOVE_W-1:0]    req_move_in,
    input  logic [NUM_REQ-1:0][BOARD_W-1:0]   req_board_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    output logic [MOVE_W-1:0]                 exec_move_out,
    output logic [BOARD_W-1:0]                exec_board_out,
    output logic                              exec_valid_out,
    input  logic [BOARD_W-1:0]                exec_board_in,
    input  logic                              exec_captured_in,
    input  logic                              exec_valid_in,
    output logic                              rsp_valid_out,
    output logic [ID_W-1:0]                   rsp_id_out,
    output logic [BOARD_W-1:0]                rsp_board_out,
    output logic                              rsp_captured_out,
    input  logic                              rsp_ready_in,
    output logic                              busy_out,
    output logic                              err_out
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = $clog2(RSP_DEPTH + EXEC_LATENCY + 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RSP_DEPTH);

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    logic [ID_W-1:0]    rr_ptr_q;
    logic [EXEC_LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [EXEC_LATENCY];
    logic [ID_W-1:0]    fifo_id_q [RSP_DEPTH];
    logic [BOARD_W-1:0] fifo_board_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_cap_q;
    logic [PTR_W-1:0]   rd_q, wr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q;

    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   occupancy;
    logic               credit_ok;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic               last_vld;
    logic               push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < EXEC_LATENCY; i++) begin
            inflight = inflight + OCC_W'(tag_vld_q[i]);
        end
    end

    // Credits use registered occupancy only, keeping rsp_ready_in off the grant path.
    assign occupancy = OCC_W'(cnt_q) + inflight;
    assign credit_ok = occupancy < DEPTH_OCC;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid_in[rr_index(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(rr_ptr_q, k);
            end
        end
        grant_vld = grant_vld && credit_ok && !rst_in;
    end

    always_comb begin
        req_ready_out = '0;
        exec_move_out = '0;
        exec_board_out = '0;
        if (grant_vld) begin
            req_ready_out[grant_idx] = 1'b1;
            exec_move_out = req_move_in[grant_idx];
            exec_board_out = req_board_in[grant_idx];
        end
    end

    assign exec_valid_out = grant_vld;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q <= '0;
        end else if (grant_vld) begin
            rr_ptr_q <= rr_index(grant_idx, 1);
        end
    end

    // Tag stage EXEC_LATENCY-1 is aligned with the executor's valid_out.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_vld_q <= '0;
            for (int i = 0; i < EXEC_LATENCY; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q[0] <= grant_vld;
            tag_id_q[0]  <= grant_idx;
            for (int i = 1; i < EXEC_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign last_vld = tag_vld_q[EXEC_LATENCY-1];
    assign push     = last_vld && exec_valid_in;
    assign pop      = (cnt_q != '0) && rsp_ready_in;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            fifo_cap_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_id_q[i]    <= '0;
                fifo_board_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_id_q[wr_q]    <= tag_id_q[EXEC_LATENCY-1];
                fifo_board_q[wr_q] <= exec_board_in;
                fifo_cap_q[wr_q]   <= exec_captured_in;
                wr_q               <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            cnt_q <= cnt_d;
        end
    end

    // A stray or missing executor result is flagged; stray data is never pushed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (last_vld != exec_valid_in) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_valid_out    = (cnt_q != '0);
    assign rsp_id_out       = fifo_id_q[rd_q];
    assign rsp_board_out    = fifo_board_q[rd_q];
    assign rsp_captured_out = fifo_cap_q[rd_q];
    assign busy_out         = (inflight != '0) || (cnt_q != '0);
    assign err_out          = err_q;

endmodule

// File: tb/tb_move_exec_arbiter.sv
// Randomized bench for move_exec_arbiter: queue-based reference model plus directed scenarios.
module tb_move_exec_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 1;
    localparam int D  = 2;
    localparam int MW = 12;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid;
    logic [N-1:0][MW-1:0] req_move;
    logic [N-1:0][BW-1:0] req_board;
    logic [N-1:0]         req_ready;
    logic [MW-1:0]        exec_move;
    logic [BW-1:0]        exec_board;
    logic                 exec_valid;
    logic [BW-1:0]        exec_board_in;
    logic                 exec_captured_in;
    logic                 exec_valid_in;
    logic                 rsp_valid;
    logic [IW-1:0]        rsp_id;
    logic [BW-1:0]        rsp_board;
    logic                 rsp_captured;
    logic                 rsp_ready;
    logic                 busy;
    logic                 err;

    move_exec_arbiter #(
        .NUM_REQ(N), .ID_W(IW), .EXEC_LATENCY(L), .RSP_DEPTH(D), .MOVE_W(MW), .BOARD_W(BW)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(req_valid), .req_move_in(req_move), .req_board_in(req_board),
        .req_ready_out(req_ready),
        .exec_move_out(exec_move), .exec_board_out(exec_board), .exec_valid_out(exec_valid),
        .exec_board_in(exec_board_in), .exec_captured_in(exec_captured_in),
        .exec_valid_in(exec_valid_in),
        .rsp_valid_out(rsp_valid), .rsp_id_out(rsp_id), .rsp_board_out(rsp_board),
        .rsp_captured_out(rsp_captured), .rsp_ready_in(rsp_ready),
        .busy_out(busy), .err_out(err)
    );

    // Executor stand-in: move = {src[5:0], dst[5:0]} on a 64-square occupancy board.
    function automatic logic [BW-1:0] apply_move(input logic [BW-1:0] b, input logic [MW-1:0] m);
        return (b & ~(64'd1 << m[11:6])) | (64'd1 << m[5:0]);
    endfunction

    function automatic logic dst_occupied(input logic [BW-1:0] b, input logic [MW-1:0] m);
        return b[m[5:0]];
    endfunction

    logic [BW-1:0] ex_board_q [L];
    logic [L-1:0]  ex_cap_q;
    logic [L-1:0]  ex_vld_q;
    logic          stray;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) ex_board_q[i] <= '0;
            ex_cap_q <= '0;
            ex_vld_q <= '0;
        end else begin
            ex_board_q[0] <= apply_move(exec_board, exec_move);
            ex_cap_q[0]   <= dst_occupied(exec_board, exec_move);
            ex_vld_q[0]   <= exec_valid;
            for (int i = 1; i < L; i++) begin
                ex_board_q[i] <= ex_board_q[i-1];
                ex_cap_q[i]   <= ex_cap_q[i-1];
                ex_vld_q[i]   <= ex_vld_q[i-1];
            end
        end
    end

    assign exec_board_in    = ex_board_q[L-1];
    assign exec_captured_in = ex_cap_q[L-1];
    assign exec_valid_in    = ex_vld_q[L-1] | stray;

    typedef struct {
        int            id;
        logic [BW-1:0] board;
        logic          cap;
        int            due;
    } item_t;

    item_t  infl_q[$];
    item_t  fifo_q[$];
    int     m_ptr = 0;
    bit     m_err = 1'b0;
    int     cyc = 0;
    bit     in_rst = 1'b0;
    logic [N-1:0] last_grant = '0;
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic cycle_check();
        int g;
        int idx;
        bit due_now;
        item_t it;
        logic [N-1:0] exp_rdy;
        g = -1;
        if (!in_rst && (fifo_q.size() + infl_q.size() < D)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[IW'(idx)]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("exec_valid", 64'(exec_valid), 64'(g >= 0));
        chk("exec_move", 64'(exec_move), (g >= 0) ? 64'(req_move[IW'(g)]) : 64'd0);
        chk("exec_board", 64'(exec_board), (g >= 0) ? 64'(req_board[IW'(g)]) : 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            chk("rsp_id", 64'(rsp_id), 64'(fifo_q[0].id));
            chk("rsp_board", 64'(rsp_board), 64'(fifo_q[0].board));
            chk("rsp_captured", 64'(rsp_captured), 64'(fifo_q[0].cap));
        end
        chk("busy", 64'(busy), 64'((infl_q.size() + fifo_q.size()) != 0));
        chk("err", 64'(err), 64'(m_err));
        last_grant = exp_rdy;
        if (!in_rst) begin
            due_now = (infl_q.size() > 0) && (infl_q[0].due == cyc);
            if (due_now != exec_valid_in) m_err = 1'b1;
            if (fifo_q.size() > 0 && rsp_ready) void'(fifo_q.pop_front());
            if (due_now) fifo_q.push_back(infl_q.pop_front());
            if (g >= 0) begin
                it.id    = g;
                it.board = apply_move(req_board[IW'(g)], req_move[IW'(g)]);
                it.cap   = dst_occupied(req_board[IW'(g)], req_move[IW'(g)]);
                it.due   = cyc + L;
                infl_q.push_back(it);
                m_ptr = (g + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = '0;
        stray = 1'b0;
        in_rst = 1'b1;
        infl_q.delete();
        fifo_q.delete();
        m_ptr = 0;
        m_err = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        in_rst = 1'b0;
    endtask

    int grants;
    int seen_ids[$];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_move = '0;
        req_board = '0;
        rsp_ready = 1'b1;
        stray = 1'b0;
        do_reset(3);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);

        // Single request from requester 2: e2e4 on a board with squares 0..15 occupied.
        req_valid = 4'b0100;
        req_move[2] = {6'd12, 6'd28};
        req_board[2] = 64'h0000_0000_0000_FFFF;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        step();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'd2);
        chk("t1_rsp_board", rsp_board, 64'h0000_0000_1000_EFFF);
        chk("t1_rsp_cap", 64'(rsp_captured), 64'd0);
        step();

        // All requesters valid, consumer always ready.
        do_reset(2);
        for (int i = 0; i < N; i++) begin
            req_move[IW'(i)] = MW'(i * 65 + 7);
            req_board[IW'(i)] = {$urandom, $urandom};
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        seen_ids.delete();
        repeat (14) begin
            if (rsp_valid) seen_ids.push_back(int'(rsp_id));
            step();
        end
        chk("t2_nresp", 64'(seen_ids.size() >= 5), 64'd1);
        if (seen_ids.size() >= 5) begin
            chk("t2_id0", 64'(seen_ids[0]), 64'd0);
            chk("t2_id1", 64'(seen_ids[1]), 64'd1);
            chk("t2_id2", 64'(seen_ids[2]), 64'd2);
            chk("t2_id3", 64'(seen_ids[3]), 64'd3);
            chk("t2_id4", 64'(seen_ids[4]), 64'd0);
        end

        // Backpressure: credits allow exactly RSP_DEPTH grants.
        do_reset(2);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        grants = 0;
        repeat (5) begin
            #1;
            if (|req_ready) grants++;
            step();
        end
        chk("t3_grants", 64'(grants), 64'd2);
        chk("t3_busy", 64'(busy), 64'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("t3_drain0", 64'(rsp_id), 64'd0);
        step();
        chk("t3_drain1", 64'(rsp_id), 64'd1);
        step();
        req_valid = 4'b0011;
        repeat (4) step();
        req_valid = '0;
        repeat (4) step();

        // Capture: destination square 44 already occupied.
        req_valid = 4'b0010;
        req_move[1] = {6'd28, 6'd44};
        req_board[1] = (64'd1 << 28) | (64'd1 << 44);
        step();
        req_valid = '0;
        step();
        chk("t4_rsp_id", 64'(rsp_id), 64'd1);
        chk("t4_rsp_cap", 64'(rsp_captured), 64'd1);
        chk("t4_rsp_board", rsp_board, 64'h0000_1000_0000_0000);
        repeat (3) step();

        // Reset with one result in flight and one buffered.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        step();
        chk("t5_busy_pre", 64'(busy), 64'd1);
        do_reset(2);
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_err", 64'(err), 64'd0);
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        #1;
        chk("t5_lowest", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        repeat (4) step();

        // Stray executor result with nothing outstanding.
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (3) step();
        chk("t6_err_sticky", 64'(err), 64'd1);
        do_reset(2);
        #1;
        chk("t6_err_clear", 64'(err), 64'd0);

        // Randomized traffic; requesters hold data until granted.
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[IW'(i)] || last_grant[IW'(i)]) begin
                    req_valid[IW'(i)] = ($urandom_range(0, 9) < 6);
                    req_move[IW'(i)] = MW'($urandom);
                    req_board[IW'(i)] = {$urandom, $urandom};
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
